// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched -- multiply/divide scheduler for the five-stage MIPS pipeline.
//
// Accepts mult/div/madd-family requests and mthi/mtlo writes from the E
// stage. The architectural result is computed in the cycle the request is
// accepted, parked in pending registers, and committed to HI/LO after a
// fixed busy period (MULT_CYCLES or DIV_CYCLES) counted by a down-counter.
// While an operation is in flight, a D-stage HI/LO consumer is stalled.
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu and the madd/msub family (>=1)
//   DIV_CYCLES   busy cycles for div/divu (>=1)
//
// Configuration macro
//   MD_MADD_EN   when defined, MDOp 4..7 perform maddu/madd/msubu/msub;
//                when undefined they are no-ops and the accumulator is absent.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset, clears all state
//   Start     in   E-stage md operation valid
//   MDOp      in   3  0 multu,1 mult,2 divu,3 div,4 maddu,5 madd,6 msubu,7 msub
//   A, B      in   32 rs/rt operands (post-forwarding)
//   HIWe      in   mthi: write A into HI
//   LOWe      in   mtlo: write A into LO
//   Flush     in   suppresses Start/HIWe/LOWe sampled in the same cycle
//   MD_D      in   D-stage instruction touches HI/LO or is an md op
//   HI, LO    out  32 architectural HI/LO
//   Busy      out  operation in flight
//   Stall_MD  out  combinational D-stage stall request
// ---------------------------------------------------------------------------
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HIWe,
   input  logic        LOWe,
   input  logic        Flush,
   input  logic        MD_D,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Busy,
   output logic        Stall_MD
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [31:0]        hi_q;
   logic [31:0]        lo_q;
   logic [31:0]        pend_hi_q;
   logic [31:0]        pend_lo_q;

   logic               is_signed;
   logic signed [63:0] a_x;
   logic signed [63:0] b_x;
   logic signed [63:0] prod;
   logic [63:0]        div_res;
   logic [63:0]        res_d;
   logic [CNT_W-1:0]   cnt_load;
   logic               op_ok;
   logic               start_seen;
   logic               start_acc;

   // Signed divide by magnitudes: quotient truncates toward zero, remainder
   // takes the dividend's sign. Magnitude form keeps -2^31 / -1 well defined
   // (quotient wraps to 0x80000000, remainder 0). Returns {rem, quo}.
   function automatic logic [63:0] div_rq(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
      logic [31:0] ua;
      logic [31:0] ub;
      logic [31:0] q;
      logic [31:0] r;
      ua = (sgn && a[31]) ? (32'd0 - a) : a;
      ub = (sgn && b[31]) ? (32'd0 - b) : b;
      q  = ua / ub;
      r  = ua % ub;
      if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
      if (sgn && a[31])           r = 32'd0 - r;
      return {r, q};
   endfunction

   // MDOp[0] selects signed for every op family, so one 64x64 multiplier
   // with sign- or zero-extended operands serves both; the low 64 bits of
   // the product are identical either way.
   assign is_signed = MDOp[0];
   assign a_x       = {{32{is_signed & A[31]}}, A};
   assign b_x       = {{32{is_signed & B[31]}}, B};
   assign prod      = a_x * b_x;
   assign div_res   = div_rq(A, B, is_signed);

`ifdef MD_MADD_EN
   assign op_ok = 1'b1;
`else
   assign op_ok = ~MDOp[2];
`endif

   // Divides are MDOp 2/3; everything else uses the multiply latency.
   assign cnt_load   = (MDOp[2:1] == 2'b01) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
   assign start_seen = (state_q == S_IDLE) & Start & ~Flush;
   assign start_acc  = start_seen & op_ok;

   always_comb begin
      res_d = {hi_q, lo_q};
      case (MDOp)
         3'd0, 3'd1: res_d = prod;
         // Divide by zero leaves HI/LO as they were; the busy period still runs.
         3'd2, 3'd3: res_d = (B == 32'd0) ? {hi_q, lo_q} : div_res;
`ifdef MD_MADD_EN
         3'd4, 3'd5: res_d = {hi_q, lo_q} + prod;
         3'd6, 3'd7: res_d = {hi_q, lo_q} - prod;
`endif
         default:    res_d = {hi_q, lo_q};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_acc) begin
                  pend_hi_q <= res_d[63:32];
                  pend_lo_q <= res_d[31:0];
                  cnt_q     <= cnt_load;
                  state_q   <= S_RUN;
               end else if (!start_seen && !Flush) begin
                  // A start in the same cycle wins over mthi/mtlo.
                  if (HIWe) hi_q <= A;
                  if (LOWe) lo_q <= A;
               end
            end
            S_RUN: begin
               // Requests arriving here are ignored; Flush cannot cancel a
               // committed operation.
               if (cnt_q == CNT_W'(1)) begin
                  hi_q    <= pend_hi_q;
                  lo_q    <= pend_lo_q;
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign HI       = hi_q;
   assign LO       = lo_q;
   assign Busy     = (state_q == S_RUN);
   assign Stall_MD = MD_D & (Busy | (Start & ~Flush));

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic        Start;
   logic [2:0]  MDOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        HIWe;
   logic        LOWe;
   logic        Flush;
   logic        MD_D;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        Busy;
   logic        Stall_MD;

   int nchk = 0;
   int nerr = 0;

   md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
      .HIWe(HIWe), .LOWe(LOWe), .Flush(Flush), .MD_D(MD_D),
      .HI(HI), .LO(LO), .Busy(Busy), .Stall_MD(Stall_MD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (timestamp based) ----------------
   int          cyc    = 0;
   int          m_done = 0;
   logic [31:0] m_hi   = 0;
   logic [31:0] m_lo   = 0;
   logic [63:0] m_pend = 0;
   logic        m_busy = 0;

   function automatic void model_op(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [63:0] acc,
                                    output logic [63:0] res, output int n,
                                    output bit ok);
      logic [63:0] p;
      longint      sa, sb, q, r;
      ok  = 1'b1;
      res = acc;
      n   = MC;
      if (op[0]) p = longint'($signed(a)) * longint'($signed(b));
      else       p = {32'd0, a} * {32'd0, b};
      case (op)
         3'd0, 3'd1: res = p;
         3'd2: begin
            n = DC;
            if (b != 0) res = {a % b, a / b};
         end
         3'd3: begin
            n = DC;
            if (b != 0) begin
               sa  = longint'($signed(a));
               sb  = longint'($signed(b));
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
`ifdef MD_MADD_EN
            res = op[1] ? acc - p : acc + p;
`else
            ok = 1'b0;
`endif
         end
      endcase
   endfunction

   always @(posedge clk) begin
      logic [63:0] r;
      int          n;
      bit          ok;
      cyc = cyc + 1;
      if (reset) begin
         m_hi = 0; m_lo = 0; m_pend = 0; m_done = cyc;
      end else if (cyc <= m_done) begin
         if (cyc == m_done) {m_hi, m_lo} = m_pend;
      end else if (Start && !Flush) begin
         model_op(MDOp, A, B, {m_hi, m_lo}, r, n, ok);
         if (ok) begin
            m_pend = r;
            m_done = cyc + n;
         end
      end else if (!Flush) begin
         if (HIWe) m_hi = A;
         if (LOWe) m_lo = A;
      end
      m_busy = (cyc < m_done);
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in;
      Start = 0; MDOp = 0; A = 0; B = 0; HIWe = 0; LOWe = 0; Flush = 0; MD_D = 0;
   endtask

   task automatic mthi(input logic [31:0] v);
      HIWe = 1; A = v; cyc1; HIWe = 0;
   endtask

   task automatic mtlo(input logic [31:0] v);
      LOWe = 1; A = v; cyc1; LOWe = 0;
   endtask

   typedef struct {
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          cycles;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int n;
      vecs[0] = '{32'h0, 32'h0, 3'd1, 32'hFFFFFFFE, 32'd3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1] = '{32'h0, 32'h0, 3'd0, 32'hFFFFFFFE, 32'd3, MC, 32'h00000002, 32'hFFFFFFFA};
      vecs[2] = '{32'h0, 32'h0, 3'd3, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 3'd2, 32'd7, 32'd0, DC, 32'h12345678, 32'h9ABCDEF0};
      vecs[4] = '{32'h0, 32'h0, 3'd3, 32'h80000000, 32'hFFFFFFFF, DC, 32'h00000000, 32'h80000000};
      vecs[5] = '{32'h5, 32'h5, 3'd3, 32'd7, 32'hFFFFFFFE, DC, 32'h00000001, 32'hFFFFFFFD};
`ifdef MD_MADD_EN
      vecs[6] = '{32'h0, 32'hFFFFFFFF, 3'd5, 32'd1, 32'd1, MC, 32'h00000001, 32'h00000000};
      vecs[7] = '{32'h0, 32'h0, 3'd6, 32'd1, 32'd1, MC, 32'hFFFFFFFF, 32'hFFFFFFFF};
`else
      vecs[6] = '{32'h0, 32'hFFFFFFFF, 3'd5, 32'd1, 32'd1, 0, 32'h00000000, 32'hFFFFFFFF};
      vecs[7] = '{32'h0, 32'h0, 3'd6, 32'd1, 32'd1, 0, 32'h00000000, 32'h00000000};
`endif

      // reset state
      idle_in();
      reset = 1;
      cyc1; cyc1;
      reset = 0;
      MD_D = 1;
      #1;
      chk("reset HI", HI, 0);
      chk("reset LO", LO, 0);
      chk("reset Busy", Busy, 0);
      chk("reset Stall_MD", Stall_MD, 0);
      MD_D = 0;

      // table-driven operations
      for (int i = 0; i < 8; i++) begin
         mthi(vecs[i].pre_hi);
         mtlo(vecs[i].pre_lo);
         chk($sformatf("v%0d mthi", i), HI, vecs[i].pre_hi);
         chk($sformatf("v%0d mtlo", i), LO, vecs[i].pre_lo);
         Start = 1; MDOp = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
         cyc1;
         Start = 0;
         n = 0;
         while (Busy && n < 64) begin
            n++;
            if (n == 1) chk($sformatf("v%0d LO held", i), LO, vecs[i].pre_lo);
            cyc1;
         end
         chk($sformatf("v%0d busy cycles", i), n, vecs[i].cycles);
         chk($sformatf("v%0d HI", i), HI, vecs[i].exp_hi);
         chk($sformatf("v%0d LO", i), LO, vecs[i].exp_lo);
      end

      // Stall_MD with MD_D held across a mult
      MD_D = 1; Start = 1; MDOp = 3'd1; A = 2; B = 3;
      #1;
      chk("stall start cycle", Stall_MD, 1);
      cyc1;
      Start = 0;
      for (int k = 1; k <= MC; k++) begin
         chk($sformatf("stall busy cycle %0d", k), Stall_MD, 1);
         cyc1;
      end
      chk("stall released", Stall_MD, 0);
      chk("stall LO", LO, 6);
      MD_D = 0;

      // Start together with Flush is dropped
      mthi(32'h11); mtlo(32'h22);
      Start = 1; Flush = 1; MDOp = 3'd1; A = 5; B = 5;
      cyc1;
      Start = 0; Flush = 0;
      chk("flushed start Busy", Busy, 0);
      chk("flushed start HI", HI, 32'h11);
      chk("flushed start LO", LO, 32'h22);

      // Flush during RUN does not cancel
      Start = 1;
      cyc1;
      Start = 0; Flush = 1;
      cyc1; cyc1;
      Flush = 0;
      cyc1; cyc1;
      chk("flush-in-run still busy", Busy, 1);
      cyc1;
      chk("flush-in-run done", Busy, 0);
      chk("flush-in-run HI", HI, 0);
      chk("flush-in-run LO", LO, 25);

      // Start wins over simultaneous mthi/mtlo
      mthi(32'h33); mtlo(32'h44);
      Start = 1; HIWe = 1; LOWe = 1; MDOp = 3'd1; A = 2; B = 2;
      cyc1;
      Start = 0; HIWe = 0; LOWe = 0;
      chk("start+mthi HI held", HI, 32'h33);
      chk("start+mtlo LO held", LO, 32'h44);
      repeat (MC) cyc1;
      chk("start+mt LO result", LO, 4);

      // reset in the middle of a div
      mthi(32'hAA); mtlo(32'hBB);
      Start = 1; MDOp = 3'd3; A = 100; B = 7;
      cyc1;
      Start = 0;
      cyc1;
      reset = 1;
      cyc1;
      reset = 0;
      chk("mid-div reset Busy", Busy, 0);
      chk("mid-div reset HI", HI, 0);
      chk("mid-div reset LO", LO, 0);
      repeat (DC + 2) cyc1;
      chk("mid-div no late Busy", Busy, 0);
      chk("mid-div no late HI", HI, 0);
      chk("mid-div no late LO", LO, 0);

      // randomized run against the reference model
      for (int k = 0; k < 3000; k++) begin
         chk("rand Busy", Busy, m_busy);
         chk("rand HI", HI, m_hi);
         chk("rand LO", LO, m_lo);
         reset = ($urandom_range(0, 199) == 0);
         Start = ($urandom_range(0, 3) == 0);
         MDOp  = 3'($urandom_range(0, 7));
         HIWe  = ($urandom_range(0, 5) == 0);
         LOWe  = ($urandom_range(0, 5) == 0);
         Flush = ($urandom_range(0, 7) == 0);
         MD_D  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       begin A = 32'h80000000; B = 32'hFFFFFFFF; end
            1:       begin A = $urandom; B = 0; end
            2:       begin A = 32'($urandom_range(0, 20)); B = 32'($urandom_range(0, 5)) - 32'd2; end
            default: begin A = $urandom; B = $urandom; end
         endcase
         #1;
         chk("rand Stall_MD", Stall_MD, MD_D & (m_busy | (Start & ~Flush)));
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the five-stage MIPS pipeline. It accepts mult/div/madd requests and HI/LO writes from the E stage and models the multi-cycle latency with a down-counter. It holds HI/LO and raises a D-stage stall while a D-stage HI/LO consumer would otherwise read a stale or in-flight result. It sits beside the E-stage ALU and feeds the hazard logic alongside the forwarding/stall units.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family); ≥1
- DIV_CYCLES, 10, busy cycles for div/divu; ≥1
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; clears all state
- Start  in  1  E-stage md operation valid this cycle
- MDOp  in  3  0 multu, 1 mult, 2 divu, 3 div, 4 maddu, 5 madd, 6 msubu, 7 msub
- A, B  in  32 each  rs/rt operand values (post-forwarding)
- HIWe, LOWe  in  1 each  mthi/mtlo in E; write A into HI/LO
- Flush  in  1  exception/interrupt this cycle; suppresses Start/HIWe/LOWe sampled in the same cycle
- MD_D  in  1  D-stage instruction is mfhi/mflo/mthi/mtlo or any md op
- HI, LO  out  32 each  architectural HI/LO; reset 0
- Busy  out  1  operation in flight; reset 0
- Stall_MD  out  1  combinational: MD_D & (Busy | (Start & ~Flush)); reset 0

## Operation
- States: IDLE, RUN. Internal cnt (4 bits min, sized to max(MULT_CYCLES, DIV_CYCLES)), pending hi/lo regs.
- IDLE, Start & ~Flush: compute result into pending regs, load cnt with MULT_CYCLES or DIV_CYCLES, go to RUN.
- RUN: cnt decrements each cycle. At cnt==1 the next edge writes pending to HI/LO, clears Busy, and returns to IDLE.
- Busy == (state == RUN).
- Arithmetic:
  - mult: signed 32×32→64. multu: unsigned. {HI,LO} = product.
  - div: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. divu: unsigned.
  - Divide by zero: HI/LO keep their old values; still busy DIV_CYCLES.
  - madd/maddu: {HI,LO} += product. msub/msubu: {HI,LO} −= product. Both are 64-bit modulo and use the HI/LO value at Start.
- HIWe/LOWe: accepted only in IDLE with ~Flush; write next edge with no busy period. If asserted together with Start, Start wins and the writes are dropped. This combination is illegal but defined.
- Start/HIWe/LOWe while Busy: ignored; cannot occur in practice because Stall_MD holds the instruction in D.
- Flush never cancels an operation already in RUN; the instruction has committed past E.
- reset at any time, including mid-RUN: state IDLE, cnt 0, HI = LO = 0, pending discarded.

## Timing
- Start sampled at edge t. Busy is high for cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES). HI/LO take the new value after edge t+N, visible in cycle t+N+1 with Busy low.
- The mfhi that followed the op into D stalls cycles t … t+N and reads the correct HI in D at t+N+1.
- Back-to-back: a new Start is accepted in the first cycle Busy is low.
- mthi/mtlo: HI/LO updated after the same edge that samples HIWe/LOWe.

## Configuration
- MD_MADD_EN defined: MDOp 4–7 perform madd/maddu/msub/msubu as above.
- MD_MADD_EN undefined: MDOp 4–7 are treated as no-ops. No state change, Busy stays 0, and the accumulate adder is removed.

## Test plan
- mult A=0xFFFFFFFE (−2), B=3, MULT_CYCLES=5 → Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; same inputs with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 → HI/LO unchanged, Busy 10 cycles.
- Start with MD_D held 1 → Stall_MD high from the Start cycle through the last Busy cycle, low the following cycle.
- Start & Flush in the same cycle → Busy stays 0, HI/LO unchanged; Flush during RUN → result still lands on schedule.
- reset asserted at cycle 3 of a div → next cycle Busy=0, HI=LO=0, no later write.
- MD_MADD_EN: HI:LO=0x0:0xFFFFFFFF, madd 1×1 → HI=1, LO=0; without the macro the same op leaves HI:LO unchanged and Busy=0.
